// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/ack, redirect from the
// branch logic, and the valid/ready hand-off to the decoder.
//   master : the fetch unit (drives imem_req/imem_addr and dec_* outputs)
//   slave  : the surrounding environment (memory, branch logic, decoder)
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [31:0] dec_pc_plus8;

    modport master (
        output imem_req, imem_addr, dec_valid, dec_instr, dec_pc, dec_pc_plus8,
        input  imem_ack, imem_rdata, redirect, redirect_pc, dec_ready
    );

    modport slave (
        input  imem_req, imem_addr, dec_valid, dec_instr, dec_pc, dec_pc_plus8,
        output imem_ack, imem_rdata, redirect, redirect_pc, dec_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one word-aligned request at a time,
// buffers up to two fetched {instr, pc} pairs and presents them in order
// to the decoder. A redirect flushes the buffer; if it lands while a
// request is in flight, the unit drains (discards) that response first.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fetch_unit_if.master (imem_*, redirect*, dec_*)
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic          clk,
    input logic          rst_n,
    fetch_unit_if.master bus
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 2;

    typedef enum logic {FETCH, DRAIN} state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fifo_entry_t;

    state_e             state_q;
    logic [XLEN-1:0]    fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]    addr_q;
    logic               req_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               rd_ptr_q, wr_ptr_q;
    fifo_entry_t        fifo_q [DEPTH];

    logic complete_c;
    logic drain_d;
    logic push_c;
    logic pop_c;
    logic dec_valid_c;
    logic unused_c;

    // Low address bits of a redirect target are dropped.
    assign unused_c = ^bus.redirect_pc[1:0];

    assign complete_c  = req_q & bus.imem_ack;
    assign dec_valid_c = (count_q != '0);
    // Stay in / enter DRAIN while a request that must be discarded is still in flight.
    assign drain_d     = req_q & ~bus.imem_ack & ((state_q == DRAIN) | bus.redirect);
    assign push_c      = (state_q == FETCH) & complete_c & ~bus.redirect;
    assign pop_c       = dec_valid_c & bus.dec_ready & ~bus.redirect;

    // Buffer occupancy; redirect flushes.
    always_comb begin
        count_d = count_q;
        if (bus.redirect) begin
            count_d = '0;
        end else if (push_c && !pop_c) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_c && !push_c) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Next fetch address; +4 wraps naturally at 2^32.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (bus.redirect) begin
            fetch_pc_d = {bus.redirect_pc[XLEN-1:2], 2'b00};
        end else if (push_c) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
    end

    // FSM and request control. An outstanding request keeps its address;
    // otherwise the bus address follows fetch_pc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            req_q      <= 1'b0;
            count_q    <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
        end else begin
            state_q    <= drain_d ? DRAIN : FETCH;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= drain_d ? addr_q : fetch_pc_d;
            req_q      <= drain_d | (count_d != CNT_W'(DEPTH));
            count_q    <= count_d;
            if (bus.redirect) begin
                rd_ptr_q <= 1'b0;
                wr_ptr_q <= 1'b0;
            end else begin
                if (pop_c)  rd_ptr_q <= ~rd_ptr_q;
                if (push_c) wr_ptr_q <= ~wr_ptr_q;
            end
        end
    end

    // Buffer storage; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_q[wr_ptr_q] <= '{instr: bus.imem_rdata, pc: addr_q};
        end
    end

    assign bus.imem_req     = req_q;
    assign bus.imem_addr    = addr_q;
    assign bus.dec_valid    = dec_valid_c;
    assign bus.dec_instr    = fifo_q[rd_ptr_q].instr;
    assign bus.dec_pc       = fifo_q[rd_ptr_q].pc;
    assign bus.dec_pc_plus8 = fifo_q[rd_ptr_q].pc + XLEN'(8);
endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: a queue-based reference model tracks the
// expected request, address and decoder-facing entries; every cycle's
// outputs are compared against it, plus directed scenarios with
// hand-computed literal expectations.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    int checks = 0;
    int failures = 0;

    // Reference model state
    ent_t        mq[$];
    logic [31:0] m_fpc;
    logic [31:0] m_addr;
    bit          m_req;
    bit          m_drain;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_fpc   = RESET_PC;
        m_addr  = RESET_PC;
        m_req   = 1'b0;
        m_drain = 1'b0;
    endtask

    // One rising edge of the reference behaviour.
    task automatic model_step();
        bit done;
        if (!rst_n) begin
            model_reset();
            return;
        end
        done = m_req && bus.imem_ack;
        if (bus.redirect) begin
            mq.delete();
            m_fpc = {bus.redirect_pc[31:2], 2'b00};
            if (m_req && !bus.imem_ack) m_drain = 1'b1;
            else if (done)              m_drain = 1'b0;
        end else begin
            if (mq.size() > 0 && bus.dec_ready) void'(mq.pop_front());
            if (done) begin
                if (!m_drain) begin
                    mq.push_back('{instr: bus.imem_rdata, pc: m_addr});
                    m_fpc = m_addr + 32'd4;
                end
                m_drain = 1'b0;
            end
        end
        if (m_drain) begin
            m_req = 1'b1;
        end else begin
            m_req  = (mq.size() < 2);
            m_addr = m_fpc;
        end
    endtask

    task automatic compare();
        chk("imem_req", 32'(bus.imem_req), 32'(m_req));
        if (m_req) chk("imem_addr", bus.imem_addr, m_addr);
        chk("dec_valid", 32'(bus.dec_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("dec_instr", bus.dec_instr, mq[0].instr);
            chk("dec_pc", bus.dec_pc, mq[0].pc);
            chk("dec_pc_plus8", bus.dec_pc_plus8, mq[0].pc + 32'd8);
        end
    endtask

    // Drive inputs, advance one clock, check outputs at the falling edge.
    task automatic step(input logic ack, input logic [31:0] rdata, input logic redir,
                        input logic [31:0] rpc, input logic ready);
        bus.imem_ack    = ack;
        bus.imem_rdata  = rdata;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        bus.dec_ready   = ready;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("rst_req", 32'(bus.imem_req), 32'h0);
        chk("rst_valid", 32'(bus.dec_valid), 32'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = '0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.dec_ready   = 1'b0;
        @(negedge clk);

        // Streaming: zero-wait memory returning the address as data.
        do_reset();
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("first_req", 32'(bus.imem_req), 32'h1);
        chk("first_addr", bus.imem_addr, 32'h0);
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 32'(k * 4), 1'b0, 32'h0, 1'b1);
            chk("stream_pc", bus.dec_pc, 32'(k * 4));
            chk("stream_pc8", bus.dec_pc_plus8, 32'(k * 4 + 8));
            chk("stream_instr", bus.dec_instr, 32'(k * 4));
        end

        // Back-pressure: buffer fills at two entries, request drops.
        do_reset();
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, 32'(k * 4), 1'b0, 32'h0, 1'b0);
        chk("full_req", 32'(bus.imem_req), 32'h0);
        chk("full_head", bus.dec_pc, 32'h0);
        step(1'b1, 32'h8, 1'b0, 32'h0, 1'b1);
        chk("bp_pc4", bus.dec_pc, 32'h4);
        chk("bp_req", 32'(bus.imem_req), 32'h1);
        chk("bp_addr", bus.imem_addr, 32'h8);
        step(1'b1, 32'h8, 1'b0, 32'h0, 1'b1);
        chk("bp_pc8", bus.dec_pc, 32'h8);

        // Redirect during an outstanding request: drain, then refetch.
        do_reset();
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 4; k++) step(1'b1, 32'(k * 4), 1'b0, 32'h0, 1'b1);
        chk("pre_addr", bus.imem_addr, 32'h10);
        step(1'b0, 32'h0, 1'b1, 32'h103, 1'b1);
        chk("drain_addr", bus.imem_addr, 32'h10);
        chk("drain_req", 32'(bus.imem_req), 32'h1);
        chk("drain_valid", 32'(bus.dec_valid), 32'h0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("drain_hold", bus.imem_addr, 32'h10);
        step(1'b1, 32'hDEAD_0010, 1'b0, 32'h0, 1'b1);
        chk("drain_drop", 32'(bus.dec_valid), 32'h0);
        chk("refetch_addr", bus.imem_addr, 32'h100);
        step(1'b1, 32'h1234_5678, 1'b0, 32'h0, 1'b1);
        chk("refetch_pc", bus.dec_pc, 32'h100);
        chk("refetch_instr", bus.dec_instr, 32'h1234_5678);

        // Redirect with a full buffer and a ready decoder.
        do_reset();
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, 32'(k * 4), 1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h0BAD, 1'b1, 32'h200, 1'b1);
        chk("flush_valid", 32'(bus.dec_valid), 32'h0);
        chk("flush_req", 32'(bus.imem_req), 32'h1);
        chk("flush_addr", bus.imem_addr, 32'h200);
        step(1'b1, 32'h55, 1'b0, 32'h0, 1'b1);
        chk("flush_pc", bus.dec_pc, 32'h200);

        // Address wrap, asynchronous reset mid-request, stray ack.
        do_reset();
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h0, 1'b1, 32'hFFFF_FFFE, 1'b1);
        chk("wrap_align", bus.imem_addr, 32'hFFFF_FFFC);
        step(1'b1, 32'hCAFE, 1'b0, 32'h0, 1'b0);
        chk("wrap_addr", bus.imem_addr, 32'h0);
        chk("wrap_pc", bus.dec_pc, 32'hFFFF_FFFC);
        chk("wrap_pc8", bus.dec_pc_plus8, 32'h4);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_req", 32'(bus.imem_req), 32'h0);
        chk("async_valid", 32'(bus.dec_valid), 32'h0);
        step(1'b1, 32'h99, 1'b0, 32'h0, 1'b1);
        rst_n = 1'b1;
        step(1'b1, 32'h77, 1'b0, 32'h0, 1'b1);
        chk("stray_valid", 32'(bus.dec_valid), 32'h0);
        chk("stray_req", 32'(bus.imem_req), 32'h1);
        chk("stray_addr", bus.imem_addr, 32'h0);

        // Randomized traffic against the model.
        do_reset();
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 99) < 60, $urandom,
                 $urandom_range(0, 99) < 6, $urandom,
                 $urandom_range(0, 99) < 65);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
